encrypt_rc4: RTL

//  RC4 stream encryptor: encrypts an NUM_BYTES plaintext block under a KEY_BYTES-byte key.
//  It is the transmit-side counterpart of decrypt_rc4/codebreaker and produces ciphertext

---
 rtl/encrypt_rc4.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/encrypt_rc4.sv
// RC4 stream encryptor: per block runs a full key schedule, then generates keystream
// two cycles per byte and XORs it onto the plaintext latched at start.
module encrypt_rc4 #(
  parameter int unsigned NUM_BYTES = 16,
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [8*NUM_BYTES-1:0] bytes_in,
  output logic [8*NUM_BYTES-1:0] bytes_out,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned KW     = 8 * KEY_BYTES;
  localparam int unsigned DW     = 8 * NUM_BYTES;
  localparam logic [3:0]  LAST_B = 4'(NUM_BYTES - 1);
  localparam logic [1:0]  LAST_K = 2'(KEY_BYTES - 1);

  typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA_A, PRGA_B, DONE} state_e;

  state_e        state_q, state_d;
  logic [7:0]    s_q [256];
  logic [7:0]    s_d [256];
  logic [7:0]    i_q, i_d, j_q, j_d;
  logic [3:0]    b_q, b_d;
  logic [1:0]    k_q, k_d;
  logic          armed_q, armed_d;
  logic [KW-1:0] key_q, key_d;
  logic [DW-1:0] pt_q, pt_d, ct_q, ct_d, out_q, out_d;
  logic          busy_q, busy_d, done_q, done_d;

  logic [7:0] s_i, s_j, s_jk, key_byte, pt_byte, j_ksa, i_inc, t_idx, ks;

  // S-box reads shared by the KSA and PRGA steps
  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++)
      if (k_q == 2'(n)) key_byte = key_q[KW-1-8*n -: 8];
    pt_byte = '0;
    for (int n = 0; n < NUM_BYTES; n++)
      if (b_q == 4'(n)) pt_byte = pt_q[DW-1-8*n -: 8];
    s_i   = s_q[i_q];
    s_j   = s_q[j_q];
    i_inc = 8'(i_q + 8'd1);
    j_ksa = 8'(j_q + s_i + key_byte);
    s_jk  = s_q[j_ksa];
    t_idx = 8'(s_i + s_j);
    // keystream byte taken from the post-swap S-box
    if (t_idx == i_q)      ks = s_j;
    else if (t_idx == j_q) ks = s_i;
    else                   ks = s_q[t_idx];
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    i_d     = i_q;
    j_d     = j_q;
    b_d     = b_q;
    k_d     = k_q;
    armed_d = armed_q;
    key_d   = key_q;
    pt_d    = pt_q;
    ct_d    = ct_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (!start) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          key_d   = key;
          pt_d    = bytes_in;
          busy_d  = 1'b1;
          state_d = INIT;
        end
      end
      INIT: begin
        for (int n = 0; n < 256; n++) s_d[n] = 8'(n);
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        state_d = KSA;
      end
      KSA: begin
        s_d[i_q]   = s_jk;
        s_d[j_ksa] = s_i;
        j_d        = j_ksa;
        i_d        = i_inc;
        k_d        = (k_q == LAST_K) ? 2'd0 : 2'(k_q + 2'd1);
        if (i_q == 8'hFF) begin
          j_d     = '0;
          b_d     = '0;
          state_d = PRGA_A;
        end
      end
      PRGA_A: begin
        i_d     = i_inc;
        j_d     = 8'(j_q + s_q[i_inc]);
        state_d = PRGA_B;
      end
      PRGA_B: begin
        s_d[i_q] = s_j;
        s_d[j_q] = s_i;
        for (int n = 0; n < NUM_BYTES; n++)
          if (b_q == 4'(n)) ct_d[DW-1-8*n -: 8] = pt_byte ^ ks;
        b_d     = 4'(b_q + 4'd1);
        state_d = (b_q == LAST_B) ? DONE : PRGA_A;
      end
      DONE: begin
        out_d   = ct_q;
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int n = 0; n < 256; n++) s_q[n] <= '0;
      i_q     <= '0;
      j_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      armed_q <= 1'b1;
      key_q   <= '0;
      pt_q    <= '0;
      ct_q    <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      i_q     <= i_d;
      j_q     <= j_d;
      b_q     <= b_d;
      k_q     <= k_d;
      armed_q <= armed_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      ct_q    <= ct_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bytes_out = out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
